// File: rtl/gray_sequencer_pkg.sv
// rtl/gray_sequencer_pkg.sv - shared state encoding and constants for the Gray code sequencer
package gray_sequencer_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Width of the completed-pass counter (wraps 255 -> 0)
  localparam int PASS_CNT_W = 8;

endpackage

// File: rtl/bin2gray_n.sv
// rtl/bin2gray_n.sv - purely combinational WIDTH-bit binary to Gray converter
module bin2gray_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  // Each Gray bit is the XOR of a binary bit and its upper neighbour
  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_sequencer.sv
// rtl/gray_sequencer.sv - up/down Gray code sequencer with ready/valid output and pass counting
module gray_sequencer
  import gray_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic                  up_dn,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      bin_out,
  output logic [WIDTH-1:0]      gray_out,
  output logic                  busy,
  output logic                  done,
  output logic [PASS_CNT_W-1:0] pass_cnt
);

  localparam logic [WIDTH-1:0]      BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PASS_CNT_W-1:0] PASS_ONE = {{(PASS_CNT_W-1){1'b0}}, 1'b1};

  seq_state_t            r_state;
  logic [WIDTH-1:0]      r_bin;
  logic [WIDTH-1:0]      r_limit;
  logic                  r_mode;
  logic                  r_up;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [PASS_CNT_W-1:0] r_pass_cnt;

  logic                  w_xfer;
  logic                  w_terminal;
  logic [WIDTH-1:0]      w_gray;

  // A code is consumed whenever the consumer accepts a valid output
  assign w_xfer     = r_valid && out_ready;
  // Last code of a pass depends on the direction latched at start
  assign w_terminal = r_up ? (r_bin == r_limit) : (r_bin == '0);

  // Gray output follows the binary register with no extra pipeline stage
  bin2gray_n #(
    .WIDTH(WIDTH)
  ) u_bin2gray (
    .i_bin (r_bin),
    .o_gray(w_gray)
  );

  // Control FSM: all outputs and configuration are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_limit    <= '0;
      r_mode     <= 1'b0;
      r_up       <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_mode  <= mode;
            r_up    <= up_dn;
            r_limit <= limit;
            r_bin   <= up_dn ? '0 : limit;
          end
        end
        RUN: begin
          // Abort wins over terminal detection; an accepted code does not advance
          if (stop) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            if (w_terminal) begin
              if (r_mode) begin
                r_bin      <= r_up ? '0 : r_limit;
                r_pass_cnt <= r_pass_cnt + PASS_ONE;
              end else begin
                r_state <= DONE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_bin <= r_up ? (r_bin + BIN_ONE) : (r_bin - BIN_ONE);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign bin_out   = r_bin;
  assign gray_out  = w_gray;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass_cnt  = r_pass_cnt;

endmodule

// File: tb/tb_gray_sequencer.sv
// tb/tb_gray_sequencer.sv - self-checking bench for gray_sequencer (WIDTH=4)
module tb_gray_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         mode;
  logic         up_dn;
  logic [W-1:0] limit;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] bin_out;
  logic [W-1:0] gray_out;
  logic         busy;
  logic         done;
  logic [7:0]   pass_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  gray_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .up_dn    (up_dn),
    .limit    (limit),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .busy     (busy),
    .done     (done),
    .pass_cnt (pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic begin_run(input logic [W-1:0] lim, input logic up, input logic cont);
    limit = lim;
    up_dn = up;
    mode  = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expected codes of one pass, in transfer order
  task automatic push_pass(inout int q[$], input int lim, input bit up);
    for (int k = 0; k <= lim; k++) q.push_back(up ? k : lim - k);
  endtask

  initial begin
    int      q[$];
    int      exp_pass;
    int      xfers;
    int      target;
    int      lim;
    bit      up;
    bit      cont;
    bit      rdy;
    bit      finished;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; up_dn = 1'b1;
    limit = '0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_gray", gray_out, 0);
    chk("rst_pass", pass_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Single up pass to limit 4 with a ready consumer
    begin_run(4'd4, 1'b1, 1'b0);
    chk("up_g0", gray_out, 4'b0000);
    chk("up_valid", out_valid, 1);
    chk("up_busy", busy, 1);
    tick(); chk("up_g1", gray_out, 4'b0001);
    tick(); chk("up_g2", gray_out, 4'b0011);
    tick(); chk("up_g3", gray_out, 4'b0010);
    tick(); chk("up_g4", gray_out, 4'b0110);
    tick();
    chk("up_done", done, 1);
    chk("up_done_valid", out_valid, 0);
    tick();
    chk("up_done_pulse", done, 0);
    chk("idle_hold_bin", bin_out, 4);
    chk("idle_valid", out_valid, 0);

    // Backpressure at bin 2
    begin_run(4'd4, 1'b1, 1'b0);
    tick(); tick();
    chk("bp_pre", gray_out, 4'b0011);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", gray_out, 4'b0011);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick(); chk("bp_next", gray_out, 4'b0010);
    tick(); chk("bp_last", bin_out, 4);
    tick(); chk("bp_done", done, 1);
    tick();

    // Continuous down pass wraps from 0 back to the limit
    begin_run(4'd15, 1'b0, 1'b1);
    chk("dn_first", bin_out, 15);
    for (int i = 0; i < 15; i++) tick();
    chk("dn_zero", gray_out, 4'b0000);
    chk("dn_pass0", pass_cnt, 0);
    tick();
    chk("dn_wrap_bin", bin_out, 15);
    chk("dn_wrap_gray", gray_out, 4'b1000);
    chk("dn_pass1", pass_cnt, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("dn_stop_valid", out_valid, 0);
    chk("dn_stop_done", done, 0);
    tick();

    // Stop at bin 5 together with a transfer
    begin_run(4'd9, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("stop_at", gray_out, 4'b0111);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid", out_valid, 0);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_bin", bin_out, 5);
    tick();
    chk("stop_done2", done, 0);

    // Start and new configuration during a run are ignored
    begin_run(4'd7, 1'b1, 1'b0);
    start = 1'b1; limit = 4'd2; mode = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("ign_busy", busy, 1);
    end
    chk("ign_term", gray_out, 4'b0100);
    start = 1'b0;
    tick();
    chk("ign_done", done, 1);
    tick();

    // Asynchronous reset mid-run at bin 9
    begin_run(4'd15, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    chk("ar_pre", bin_out, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_bin", bin_out, 0);
    chk("ar_gray", gray_out, 0);
    chk("ar_pass", pass_cnt, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar_idle", out_valid, 0);
    tick();
    chk("ar_idle2", busy, 0);

    // Randomised runs against a pass-list reference model
    exp_pass = 0;
    for (int r = 0; r < 14; r++) begin
      lim    = $urandom_range(0, 15);
      up     = 1'($urandom_range(0, 1));
      cont   = (r % 3 == 2);
      target = $urandom_range(5, 40);
      q.delete();
      push_pass(q, lim, up);
      out_ready = 1'b1;
      begin_run(W'(lim), up, cont);
      limit = W'($urandom);
      up_dn = 1'($urandom);
      mode  = 1'($urandom);
      xfers = 0;
      finished = 0;
      for (int c = 0; c < 400 && !finished; c++) begin
        rdy = ($urandom_range(0, 3) != 0);
        out_ready = rdy;
        stop = cont && (xfers >= target);
        chk("rnd_valid", out_valid, 1);
        chk("rnd_bin", bin_out, q[0]);
        chk("rnd_gray", gray_out, to_gray(W'(q[0])));
        if (rdy && !stop) begin
          void'(q.pop_front());
          xfers++;
          if (q.size() == 0 && cont) begin
            exp_pass = (exp_pass + 1) % 256;
            push_pass(q, lim, up);
          end
        end
        tick();
        if (stop) begin
          stop = 1'b0;
          chk("rnd_stop_valid", out_valid, 0);
          chk("rnd_stop_done", done, 0);
          finished = 1;
        end else if (q.size() == 0) begin
          chk("rnd_done", done, 1);
          chk("rnd_done_valid", out_valid, 0);
          tick();
          chk("rnd_done_pulse", done, 0);
          finished = 1;
        end
        chk("rnd_pass", pass_cnt, exp_pass);
      end
      chk("rnd_finished", finished, 1);
      out_ready = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_sequencer.md
GRAY_SEQUENCER -- requirements
Module: gray_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the code width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, a request to begin a sequence; honoured only in IDLE.
REQ-005 SHALL have port stop, input, 1, an abort request; honoured only in RUN.
REQ-006 SHALL have port mode, input, 1: 0 = single pass, 1 = continuous (wrap).
REQ-007 SHALL have port up_dn, input, 1: 1 = count up, 0 = count down; sampled at start.
REQ-008 SHALL have port limit, input, WIDTH, the terminal binary value; sampled at start.
REQ-009 SHALL have port out_ready, input, 1, the consumer ready signal.
REQ-010 SHALL have port out_valid, output, 1, asserted when bin_out/gray_out hold a code.
REQ-011 SHALL have port bin_out, output, WIDTH, the current binary count.
REQ-012 SHALL have port gray_out, output, WIDTH, equal to bin_out ^ (bin_out >> 1).
REQ-013 SHALL have port busy, output, 1, high in RUN.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse when a single pass completes.
REQ-015 SHALL have port pass_cnt, output, 8, counting completed passes in continuous mode; wraps 255->0.

Function
REQ-016 SHALL implement the states IDLE, RUN and DONE.
REQ-017 IDLE with start=1 SHALL go to RUN next cycle with out_valid=1 and bin_out=0 (up) or the latched limit (down), and SHALL latch mode, up_dn and limit.
REQ-018 A transfer SHALL occur on any cycle with out_valid && out_ready; the count SHALL advance by exactly one per transfer and never otherwise.
REQ-019 While out_valid && !out_ready, bin_out and gray_out SHALL remain stable.
REQ-020 Up count: a transfer at bin_out==limit SHALL go to DONE in single mode, or load 0 and increment pass_cnt in continuous mode.
REQ-021 Down count: a transfer at bin_out==0 SHALL go to DONE in single mode, or load the limit and increment pass_cnt in continuous mode.
REQ-022 limit=0 SHALL produce exactly one code (0) per pass.
REQ-023 DONE SHALL last one cycle with done=1 and out_valid=0, then return to IDLE.
REQ-024 stop in RUN SHALL go to IDLE next cycle with out_valid=0 and done=0; a transfer in the same cycle SHALL complete without advancing the count; stop SHALL take priority over terminal detection.
REQ-025 start outside IDLE and changes on limit, mode or up_dn during RUN SHALL be ignored.
REQ-026 gray_out SHALL be combinational from the bin_out register, with zero latency relative to bin_out.
REQ-027 In IDLE, bin_out and gray_out SHALL hold their last values; out_valid SHALL be 0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE with out_valid=0, busy=0, done=0, bin_out=0, gray_out=0, pass_cnt=0 and all latched configuration cleared, independent of clk.
REQ-029 Reset released mid-sequence SHALL leave the block in IDLE awaiting start.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the pass_cnt width constant (8).
REQ-031 The Gray conversion SHALL be a parameterised sub-module bin2gray_n (WIDTH-bit, purely combinational) instantiated once.

Verification (WIDTH=4)
REQ-032 limit=4, up, single, out_ready=1: gray_out SHALL be 0000, 0001, 0011, 0010, 0110 on consecutive cycles, followed by a done pulse, with out_valid low on the done cycle.
REQ-033 Backpressure with out_ready=0 for 3 cycles at bin=2: gray_out SHALL hold 0011 for all 3 cycles, and the next code after release SHALL be 0010 with no code skipped or repeated.
REQ-034 Continuous, down, limit=15: the code after bin 0 (gray 0000) SHALL be bin 15 (gray 1000), and pass_cnt SHALL go 0->1.
REQ-035 stop asserted at bin=5 (gray 0111): out_valid and busy SHALL be 0 the next cycle, with done never asserted.
REQ-036 rst_n low mid-run at bin=9: all outputs SHALL be 0 before the next clk edge.
REQ-037 start and limit=2 applied during a run with limit=7: the run SHALL ignore them and terminate at bin 7 (gray 0100).
